dt_tick_sequencer: RTL and testbench
====================================

# dt_tick_sequencer

Sequencer and result buffer for the dt-tick computation pipeline (cos/sin → arctan → multiply → divide). It walks the mirror theta iteration index across a frame line and issues one request at a time to the pipeline. Each returned 16-bit dt-tick is captured in a small FIFO that the pixel timing logic drains through a valid/ready handshake. It sits between the frame control logic and the dt-tick pipeline.

## Interface
- FRAME_COLUMNS_P, 360: iterations per line; index range 0..FRAME_COLUMNS_P-1, must be ≤ 4096.
- FIFO_DEPTH_P, 8: result FIFO depth; power of two, ≥ 2.
- TIMEOUT_P, 255: maximum cycles to wait for a pipeline result; 1..65535.

- clk_i  in  1  clock.
- nrst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle pulse; starts a sweep at index 0.
- stop_i  in  1  single-cycle pulse; ends the sweep after the outstanding request completes.
- theta_iteration_valid_o  out  1  single-cycle request strobe to the pipeline.
- theta_iteration_o  out  12  iteration index; stable from the strobe until the result returns.
- dt_Ticks_valid_i  in  1  result strobe from the pipeline.
- dt_Ticks_i  in  16  result value; sampled only when dt_Ticks_valid_i is high.
- tick_valid_o  out  1  FIFO not empty.
- tick_data_o  out  16  FIFO head value.
- tick_last_o  out  1  FIFO head belongs to index FRAME_COLUMNS_P-1.
- tick_ready_i  in  1  consumer accepts the head.
- busy_o  out  1  state is not IDLE.
- timeout_o  out  1  sticky pipeline-timeout flag; cleared by start_i or by reset.

## Operation
- States:
  - IDLE:
    - start_i → ISSUE.
    - Index is cleared to 0.
    - timeout_o is cleared.
  - ISSUE:
    - Condition: FIFO count < FIFO_DEPTH_P, and stop is not pending.
    - Action: pulse theta_iteration_valid_o for one cycle → WAIT.
    - If stop is pending → IDLE.
  - WAIT:
    - On dt_Ticks_valid_i: push {index==FRAME_COLUMNS_P-1, dt_Ticks_i} into the FIFO.
    - Then advance the index, wrapping from FRAME_COLUMNS_P-1 to 0.
    - Then go to ISSUE.
- Only one request is outstanding at a time. A request is issued only when a FIFO slot is free, so a push never overflows.
- stop_i in ISSUE or WAIT sets the stop-pending latch.
  - In WAIT, the result is still pushed, then the block goes to IDLE.
  - The latch is cleared on entry to IDLE.
- start_i outside IDLE is ignored.
- dt_Ticks_valid_i outside WAIT is ignored and nothing is pushed.
- FIFO:
  - Pop on tick_valid_o & tick_ready_i.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - The FIFO is not flushed on stop; it is drained by the consumer.
- Reset mid-operation:
  - State → IDLE, index → 0, FIFO emptied, counters → 0.
  - A late dt_Ticks_valid_i after reset is ignored.

## Timing
- Reset values:
  - theta_iteration_valid_o = 0, theta_iteration_o = 0.
  - tick_valid_o = 0, tick_data_o = 0, tick_last_o = 0.
  - busy_o = 0, timeout_o = 0.
- All outputs are registered.
- Start to first strobe:
  - start_i at cycle N → busy_o = 1 at N+1.
  - theta_iteration_valid_o at N+2, since the FIFO is empty.
- Result to next request:
  - dt_Ticks_valid_i at cycle M → push at M.
  - tick_valid_o = 1 at M+1 if the FIFO was empty.
  - Next strobe at M+2 if space is available.
- Read side is first-word-fall-through: after a pop, the next head is presented in the following cycle.

## Configuration
- Macro: DT_TICK_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in WAIT.
  - If it reaches TIMEOUT_P with no result: set timeout_o, push nothing, go to IDLE.
  - The counter clears on every entry to WAIT.
- Undefined:
  - No counter; WAIT persists until dt_Ticks_valid_i.
  - timeout_o is tied to 0.

## Test plan
- Basic line:
  - Stimulus: FRAME_COLUMNS_P=4, pipeline model answers 20 cycles after each strobe with 100+index, tick_ready_i=1.
  - Required: strobes carry indices 0,1,2,3,0…; ticks 100,101,102,103; tick_last_o=1 only with 103.
- Backpressure:
  - Stimulus: tick_ready_i=0, FIFO_DEPTH_P=8.
  - Required: exactly 8 strobes, then none until a pop; 9th strobe 2 cycles after the first pop.
- Stop mid-WAIT:
  - Stimulus: stop_i 5 cycles after a strobe for index 2.
  - Required: result for index 2 is pushed; busy_o falls the cycle after the push; no further strobes.
- Timeout (macro defined, TIMEOUT_P=10):
  - Stimulus: pipeline never answers.
  - Required: timeout_o=1 and busy_o=0 within 12 cycles of the strobe; the next start_i clears timeout_o.
- Reset mid-sweep:
  - Stimulus: nrst_i low while the FIFO holds 3 entries and a request is outstanding.
  - Required: all outputs go to reset values; a late dt_Ticks_valid_i is ignored; tick_valid_o stays 0.

Source files
------------

// File: rtl/dt_tick_sequencer.sv
// dt_tick_sequencer: walks the theta iteration index across a frame line,
// issues one request at a time to the dt-tick pipeline and buffers the
// returned ticks in a first-word-fall-through FIFO for the pixel timing logic.
// Optional feature: define DT_TICK_SEQ_TIMEOUT_EN to abandon a request that
// gets no pipeline result within TIMEOUT_P cycles (sets sticky timeout_o).
module dt_tick_sequencer #(
    parameter int FRAME_COLUMNS_P = 360,
    parameter int FIFO_DEPTH_P    = 8,
    parameter int TIMEOUT_P       = 255
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        start_i,
    input  logic        stop_i,
    output logic        theta_iteration_valid_o,
    output logic [11:0] theta_iteration_o,
    input  logic        dt_Ticks_valid_i,
    input  logic [15:0] dt_Ticks_i,
    output logic        tick_valid_o,
    output logic [15:0] tick_data_o,
    output logic        tick_last_o,
    input  logic        tick_ready_i,
    output logic        busy_o,
    output logic        timeout_o
);

    localparam int PTR_W = (FIFO_DEPTH_P > 1) ? $clog2(FIFO_DEPTH_P) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [11:0]      LAST_INDEX = 12'(FRAME_COLUMNS_P - 1);
    localparam logic [CNT_W-1:0] DEPTH      = CNT_W'(FIFO_DEPTH_P);

    // Reject configurations the index, FIFO and timer widths cannot represent.
    if (FRAME_COLUMNS_P < 1 || FRAME_COLUMNS_P > 4096) begin : g_bad_columns
        $error("dt_tick_sequencer: FRAME_COLUMNS_P must be 1..4096");
    end
    if (FIFO_DEPTH_P < 2 || (FIFO_DEPTH_P & (FIFO_DEPTH_P - 1)) != 0) begin : g_bad_depth
        $error("dt_tick_sequencer: FIFO_DEPTH_P must be a power of two >= 2");
    end
    if (TIMEOUT_P < 1 || TIMEOUT_P > 65535) begin : g_bad_timeout
        $error("dt_tick_sequencer: TIMEOUT_P must be 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             stop_pending, stop_pending_next;
    logic [11:0]      index, index_next;
    logic             strobe_next;
    logic             timeout_next;
    logic             push, pop;
    logic             expired;
    logic [16:0]      entry;

    logic [16:0]      mem [FIFO_DEPTH_P];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
    logic [CNT_W-1:0] count, count_next;

    assign theta_iteration_o = index;
    assign entry      = {index == LAST_INDEX, dt_Ticks_i};
    assign pop        = tick_valid_o & tick_ready_i;
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);

`ifdef DT_TICK_SEQ_TIMEOUT_EN
    logic [15:0] wait_count;

    // Count cycles spent in WAIT; held at zero elsewhere so each request starts fresh.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i)              wait_count <= '0;
        else if (state != WAIT)   wait_count <= '0;
        else                      wait_count <= wait_count + 16'd1;
    end

    assign expired = (wait_count == 16'(TIMEOUT_P - 1));
`else
    assign expired = 1'b0;
`endif

    // Next-state, request strobe, push and index sequencing.
    always_comb begin
        state_next        = state;
        stop_pending_next = stop_pending;
        index_next        = index;
        strobe_next       = 1'b0;
        timeout_next      = timeout_o;
        push              = 1'b0;
        case (state)
            IDLE: begin
                index_next = '0;
                if (start_i) begin
                    state_next   = ISSUE;
                    timeout_next = 1'b0;
                end
            end
            ISSUE: begin
                if (stop_pending || stop_i) begin
                    state_next = IDLE;
                end else if (count < DEPTH) begin
                    strobe_next = 1'b1;
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                if (stop_i) stop_pending_next = 1'b1;
                if (dt_Ticks_valid_i) begin
                    push       = 1'b1;
                    index_next = (index == LAST_INDEX) ? 12'd0 : index + 12'd1;
                    state_next = (stop_pending || stop_i) ? IDLE : ISSUE;
                end else if (expired) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next == IDLE) stop_pending_next = 1'b0;
    end

    // State register plus the registered strobe, busy and timeout outputs.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state                   <= IDLE;
            stop_pending            <= 1'b0;
            index                   <= '0;
            theta_iteration_valid_o <= 1'b0;
            busy_o                  <= 1'b0;
            timeout_o               <= 1'b0;
        end else begin
            state                   <= state_next;
            stop_pending            <= stop_pending_next;
            index                   <= index_next;
            theta_iteration_valid_o <= strobe_next;
            busy_o                  <= (state_next != IDLE);
            timeout_o               <= timeout_next;
        end
    end

    // FIFO occupancy after this cycle's push and pop.
    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + CNT_W'(1);
        else if (!push && pop) count_next = count - CNT_W'(1);
    end

    // FIFO storage; no reset needed because occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= entry;
    end

    // FIFO pointers and the registered head presented to the consumer.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            tick_valid_o <= 1'b0;
            tick_data_o  <= '0;
            tick_last_o  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            count        <= count_next;
            tick_valid_o <= (count_next != '0);
            if (push && (count == '0 || (count == CNT_W'(1) && pop))) begin
                {tick_last_o, tick_data_o} <= entry;
            end else if (pop) begin
                {tick_last_o, tick_data_o} <= mem[rd_ptr_inc];
            end
        end
    end

endmodule

// File: tb/tb_dt_tick_sequencer.sv
// Scoreboard bench for dt_tick_sequencer: tests queue expected strobe indices
// and ticks, independent monitors pop and compare when the DUT presents them.
// Build with DT_TICK_SEQ_TIMEOUT_EN defined to also exercise the timeout path.
module tb_dt_tick_sequencer;

    localparam int COLS  = 4;
    localparam int DEPTH = 8;
    localparam int TMO   = 10;
`ifdef DT_TICK_SEQ_TIMEOUT_EN
    localparam int BASIC_LAT = 8;
    localparam int RST_DLY   = 4;
`else
    localparam int BASIC_LAT = 20;
    localparam int RST_DLY   = 30;
`endif

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } tick_t;

    logic        clk_i = 1'b0;
    logic        nrst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        theta_iteration_valid_o;
    logic [11:0] theta_iteration_o;
    logic        dt_Ticks_valid_i = 1'b0;
    logic [15:0] dt_Ticks_i = 16'd0;
    logic        tick_valid_o;
    logic [15:0] tick_data_o;
    logic        tick_last_o;
    logic        tick_ready_i = 1'b0;
    logic        busy_o;
    logic        timeout_o;

    int checks = 0;
    int passes = 0;
    int strobe_count = 0;
    int base = 0;
    logic [11:0] exp_idx_q[$];
    tick_t       exp_tick_q[$];
    bit  pipe_enable = 1'b1;
    int  pipe_latency = BASIC_LAT;
    int  stall_idx = -1;

    dt_tick_sequencer #(
        .FRAME_COLUMNS_P(COLS),
        .FIFO_DEPTH_P   (DEPTH),
        .TIMEOUT_P      (TMO)
    ) dut (
        .clk_i                  (clk_i),
        .nrst_i                 (nrst_i),
        .start_i                (start_i),
        .stop_i                 (stop_i),
        .theta_iteration_valid_o(theta_iteration_valid_o),
        .theta_iteration_o      (theta_iteration_o),
        .dt_Ticks_valid_i       (dt_Ticks_valid_i),
        .dt_Ticks_i             (dt_Ticks_i),
        .tick_valid_o           (tick_valid_o),
        .tick_data_o            (tick_data_o),
        .tick_last_o            (tick_last_o),
        .tick_ready_i           (tick_ready_i),
        .busy_o                 (busy_o),
        .timeout_o              (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_strobe"},     32'(theta_iteration_valid_o), 32'd0);
        checkOutput({tag, "_index"},      32'(theta_iteration_o),       32'd0);
        checkOutput({tag, "_tick_valid"}, 32'(tick_valid_o),            32'd0);
        checkOutput({tag, "_tick_data"},  32'(tick_data_o),             32'd0);
        checkOutput({tag, "_tick_last"},  32'(tick_last_o),             32'd0);
        checkOutput({tag, "_busy"},       32'(busy_o),                  32'd0);
        checkOutput({tag, "_timeout"},    32'(timeout_o),               32'd0);
    endtask

    task automatic applyStimulus(input logic do_start, input logic do_stop);
        @(posedge clk_i); #1;
        start_i = do_start;
        stop_i  = do_stop;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        stop_i  = 1'b0;
    endtask

    function automatic tick_t expTick(input logic [15:0] data, input logic last);
        tick_t t;
        t.data = data;
        t.last = last;
        return t;
    endfunction

    task automatic waitStrobes(input int target, input int budget);
        int n = 0;
        while (strobe_count < target && n < budget) begin
            @(negedge clk_i); #1;
            n++;
        end
        checkOutput("strobe_wait", 32'(strobe_count >= target), 32'd1);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((busy_o || tick_valid_o) && n < budget) begin
            @(negedge clk_i); #1;
            n++;
        end
        checkOutput("idle_wait", 32'(busy_o || tick_valid_o), 32'd0);
    endtask

    // Request monitor: every strobe must match the next queued index.
    always @(negedge clk_i) begin
        if (nrst_i && theta_iteration_valid_o) begin
            strobe_count++;
            checkOutput("strobe_expected", 32'(exp_idx_q.size() != 0), 32'd1);
            if (exp_idx_q.size() != 0)
                checkOutput("strobe_index", 32'(theta_iteration_o), 32'(exp_idx_q.pop_front()));
        end
    end

    // Result monitor: every accepted tick must match the next queued tick.
    always @(negedge clk_i) begin
        if (nrst_i && tick_valid_o && tick_ready_i) begin
            checkOutput("tick_expected", 32'(exp_tick_q.size() != 0), 32'd1);
            if (exp_tick_q.size() != 0) begin
                tick_t t;
                t = exp_tick_q.pop_front();
                checkOutput("tick_data", 32'(tick_data_o), 32'(t.data));
                checkOutput("tick_last", 32'(tick_last_o), 32'(t.last));
            end
        end
    end

    // Pipeline model: answers each strobe with 100+index after a latency.
    initial begin
        logic [11:0] idx;
        int lat;
        forever begin
            @(negedge clk_i);
            if (nrst_i && theta_iteration_valid_o && pipe_enable) begin
                idx = theta_iteration_o;
                lat = (int'(idx) == stall_idx) ? 40 : pipe_latency;
                repeat (lat) @(posedge clk_i);
                #1;
                dt_Ticks_valid_i = 1'b1;
                dt_Ticks_i       = 16'd100 + 16'(idx);
                @(posedge clk_i); #1;
                dt_Ticks_valid_i = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit seen_valid;
        bit seen_busy;
        $display("[TB] dt_tick_sequencer bench starting");

        // Reset values
        repeat (3) @(negedge clk_i);
        checkReset("reset");
        @(posedge clk_i); #1 nrst_i = 1'b1;

        // Basic line with start/result timing
        $display("[TB] basic line");
        tick_ready_i = 1'b1;
        pipe_latency = BASIC_LAT;
        base = strobe_count;
        exp_idx_q = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd0};
        exp_tick_q.push_back(expTick(16'd100, 1'b0));
        exp_tick_q.push_back(expTick(16'd101, 1'b0));
        exp_tick_q.push_back(expTick(16'd102, 1'b0));
        exp_tick_q.push_back(expTick(16'd103, 1'b1));
        exp_tick_q.push_back(expTick(16'd100, 1'b0));
        applyStimulus(1'b1, 1'b0);
        @(negedge clk_i);
        checkOutput("busy_at_n1", 32'(busy_o), 32'd1);
        checkOutput("no_strobe_at_n1", 32'(theta_iteration_valid_o), 32'd0);
        @(negedge clk_i);
        checkOutput("strobe_at_n2", 32'(theta_iteration_valid_o), 32'd1);
        repeat (BASIC_LAT) @(negedge clk_i);
        checkOutput("tick_valid_at_push", 32'(tick_valid_o), 32'd0);
        @(negedge clk_i);
        checkOutput("tick_valid_at_m1", 32'(tick_valid_o), 32'd1);
        @(negedge clk_i);
        checkOutput("strobe_at_m2", 32'(theta_iteration_valid_o), 32'd1);
        waitStrobes(base + 5, 500);
        repeat (4) @(posedge clk_i);
        applyStimulus(1'b0, 1'b1);
        waitIdle(200);
        checkOutput("basic_idx_left", 32'(exp_idx_q.size()), 32'd0);
        checkOutput("basic_ticks_left", 32'(exp_tick_q.size()), 32'd0);

        // Stop while waiting for index 2
        $display("[TB] stop mid-wait");
        base = strobe_count;
        exp_idx_q = '{12'd0, 12'd1, 12'd2};
        exp_tick_q.push_back(expTick(16'd100, 1'b0));
        exp_tick_q.push_back(expTick(16'd101, 1'b0));
        exp_tick_q.push_back(expTick(16'd102, 1'b0));
        applyStimulus(1'b1, 1'b0);
        waitStrobes(base + 3, 500);
        repeat (4) @(posedge clk_i);
        applyStimulus(1'b0, 1'b1);
        repeat (BASIC_LAT - 5) @(negedge clk_i);
        checkOutput("stop_busy_at_push", 32'(busy_o), 32'd1);
        checkOutput("stop_fifo_empty_at_push", 32'(tick_valid_o), 32'd0);
        @(negedge clk_i);
        checkOutput("stop_busy_falls", 32'(busy_o), 32'd0);
        checkOutput("stop_result_pushed", 32'(tick_valid_o), 32'd1);
        repeat (30) @(negedge clk_i);
        checkOutput("stop_no_more_strobes", 32'(strobe_count - base), 32'd3);
        checkOutput("stop_ticks_left", 32'(exp_tick_q.size()), 32'd0);

        // Backpressure: eight strobes fill the FIFO, the ninth waits for a pop
        $display("[TB] backpressure");
        @(posedge clk_i); #1 tick_ready_i = 1'b0;
        pipe_latency = 3;
        base = strobe_count;
        exp_idx_q = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd0, 12'd1, 12'd2, 12'd3, 12'd0};
        for (int r = 0; r < 2; r++) begin
            exp_tick_q.push_back(expTick(16'd100, 1'b0));
            exp_tick_q.push_back(expTick(16'd101, 1'b0));
            exp_tick_q.push_back(expTick(16'd102, 1'b0));
            exp_tick_q.push_back(expTick(16'd103, 1'b1));
        end
        exp_tick_q.push_back(expTick(16'd100, 1'b0));
        applyStimulus(1'b1, 1'b0);
        waitStrobes(base + 8, 500);
        repeat (30) @(negedge clk_i);
        checkOutput("bp_strobes_held", 32'(strobe_count - base), 32'd8);
        checkOutput("bp_head_valid", 32'(tick_valid_o), 32'd1);
        @(posedge clk_i); #1 tick_ready_i = 1'b1;
        @(posedge clk_i); #1 tick_ready_i = 1'b0;
        @(negedge clk_i);
        checkOutput("bp_no_strobe_p1", 32'(theta_iteration_valid_o), 32'd0);
        @(negedge clk_i);
        checkOutput("bp_ninth_strobe_p2", 32'(theta_iteration_valid_o), 32'd1);
        applyStimulus(1'b0, 1'b1);
        repeat (10) @(negedge clk_i);
        checkOutput("bp_idle_after_stop", 32'(busy_o), 32'd0);
        @(posedge clk_i); #1 tick_ready_i = 1'b1;
        waitIdle(100);
        checkOutput("bp_idx_left", 32'(exp_idx_q.size()), 32'd0);
        checkOutput("bp_ticks_left", 32'(exp_tick_q.size()), 32'd0);

`ifdef DT_TICK_SEQ_TIMEOUT_EN
        // Pipeline never answers: timeout aborts the request
        $display("[TB] timeout");
        pipe_enable = 1'b0;
        exp_idx_q = '{12'd0};
        applyStimulus(1'b1, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("tmo_strobe", 32'(theta_iteration_valid_o), 32'd1);
        for (int n = 0; n < 12 && !timeout_o; n++) @(negedge clk_i);
        checkOutput("tmo_flag", 32'(timeout_o), 32'd1);
        checkOutput("tmo_busy", 32'(busy_o), 32'd0);
        checkOutput("tmo_nothing_pushed", 32'(tick_valid_o), 32'd0);
        pipe_enable = 1'b1;
`endif

        // Reset while three results are buffered and a request is outstanding
        $display("[TB] reset mid-sweep");
        @(posedge clk_i); #1 tick_ready_i = 1'b0;
        pipe_latency = 3;
        stall_idx = 3;
        base = strobe_count;
        exp_idx_q = '{12'd0, 12'd1, 12'd2, 12'd3};
        applyStimulus(1'b1, 1'b0);
        @(negedge clk_i);
        checkOutput("start_clears_timeout", 32'(timeout_o), 32'd0);
        waitStrobes(base + 4, 200);
        repeat (RST_DLY) @(negedge clk_i);
        checkOutput("rst_busy_waiting", 32'(busy_o), 32'd1);
        checkOutput("rst_no_timeout_yet", 32'(timeout_o), 32'd0);
        checkOutput("rst_fifo_holds", 32'(tick_valid_o), 32'd1);
        checkOutput("rst_head_value", 32'(tick_data_o), 32'd100);
        @(posedge clk_i); #1 nrst_i = 1'b0;
        @(negedge clk_i);
        checkReset("mid_reset");
        @(posedge clk_i); #1 nrst_i = 1'b1;
        seen_valid = 1'b0;
        seen_busy  = 1'b0;
        repeat (60) begin
            @(negedge clk_i);
            seen_valid |= tick_valid_o;
            seen_busy  |= busy_o;
        end
        checkOutput("rst_tick_valid_stays_low", 32'(seen_valid), 32'd0);
        checkOutput("rst_stays_idle", 32'(seen_busy), 32'd0);
        checkOutput("rst_index_zero", 32'(theta_iteration_o), 32'd0);
        checkOutput("rst_idx_left", 32'(exp_idx_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
